// File: rtl/mc_pkg.sv
// Shared types and encodings for the handshaked multicycle RV32I controller.
// State enum, opcode values, ALU op codes and datapath select codes.
package mc_pkg;

   typedef enum logic [3:0] {
      S_FETCH,
      S_DECODE,
      S_MEMADR,
      S_MEMREAD,
      S_MEMWB,
      S_MEMWRITE,
      S_EXECR,
      S_EXECI,
      S_ALUWB,
      S_BRANCH,
      S_JAL,
      S_JALR,
      S_JALR_LINK,
      S_LUI,
      S_AUIPC,
      S_FAULT
   } mc_state_t;

   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_RTYPE  = 7'b0110011;
   localparam logic [6:0] OP_ITYPE  = 7'b0010011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;

   localparam logic [3:0] ALU_ADD  = 4'd0;
   localparam logic [3:0] ALU_SUB  = 4'd1;
   localparam logic [3:0] ALU_AND  = 4'd2;
   localparam logic [3:0] ALU_OR   = 4'd3;
   localparam logic [3:0] ALU_XOR  = 4'd4;
   localparam logic [3:0] ALU_SLT  = 4'd5;
   localparam logic [3:0] ALU_SLTU = 4'd6;
   localparam logic [3:0] ALU_SLL  = 4'd7;
   localparam logic [3:0] ALU_SRL  = 4'd8;
   localparam logic [3:0] ALU_SRA  = 4'd9;

   // ALU decoder classes
   localparam logic [1:0] ALU_CLS_ADD    = 2'd0;
   localparam logic [1:0] ALU_CLS_BRANCH = 2'd1;
   localparam logic [1:0] ALU_CLS_FUNCT  = 2'd2;

   localparam logic [2:0] IMM_I = 3'b000;
   localparam logic [2:0] IMM_S = 3'b001;
   localparam logic [2:0] IMM_B = 3'b010;
   localparam logic [2:0] IMM_J = 3'b011;
   localparam logic [2:0] IMM_U = 3'b100;

   localparam logic [1:0] SRCA_PC    = 2'b00;
   localparam logic [1:0] SRCA_OLDPC = 2'b01;
   localparam logic [1:0] SRCA_RS1   = 2'b10;
   localparam logic [1:0] SRCA_ZERO  = 2'b11;

   localparam logic [1:0] SRCB_RS2  = 2'b00;
   localparam logic [1:0] SRCB_IMM  = 2'b01;
   localparam logic [1:0] SRCB_FOUR = 2'b10;

   localparam logic [1:0] RES_ALUOUT    = 2'b00;
   localparam logic [1:0] RES_DATA      = 2'b01;
   localparam logic [1:0] RES_ALURESULT = 2'b10;

   function automatic logic [2:0] imm_type(input logic [6:0] opcode);
      case (opcode)
         OP_STORE:         return IMM_S;
         OP_BRANCH:        return IMM_B;
         OP_JAL:           return IMM_J;
         OP_LUI, OP_AUIPC: return IMM_U;
         default:          return IMM_I;
      endcase
   endfunction

endpackage

// File: rtl/mc_controller_hs_aludec.sv
// Combinational ALU decoder: maps (class, funct3, funct7b5) to an ALU op code.
// SUB for funct3=000 only when the instruction is R-type.
module mc_aludec
   import mc_pkg::*;
#(
   parameter int ALUCTRL_W = 4
)(
   input  logic [1:0]           alu_class,
   input  logic [2:0]           funct3,
   input  logic                 funct7b5,
   input  logic                 rtype,
   output logic [ALUCTRL_W-1:0] alucontrol
);

   logic [3:0] op_code;

   always_comb begin
      op_code = ALU_ADD;
      case (alu_class)
         ALU_CLS_BRANCH: begin
            case (funct3[2:1])
               2'b00:   op_code = ALU_SUB;
               2'b10:   op_code = ALU_SLT;
               2'b11:   op_code = ALU_SLTU;
               default: op_code = ALU_ADD;
            endcase
         end
         ALU_CLS_FUNCT: begin
            case (funct3)
               3'b000:  op_code = (rtype && funct7b5) ? ALU_SUB : ALU_ADD;
               3'b001:  op_code = ALU_SLL;
               3'b010:  op_code = ALU_SLT;
               3'b011:  op_code = ALU_SLTU;
               3'b100:  op_code = ALU_XOR;
               3'b101:  op_code = funct7b5 ? ALU_SRA : ALU_SRL;
               3'b110:  op_code = ALU_OR;
               default: op_code = ALU_AND;
            endcase
         end
         default: op_code = ALU_ADD;
      endcase
   end

   assign alucontrol = ALUCTRL_W'(op_code);

endmodule

// File: rtl/mc_controller_hs.sv
// Multicycle RV32I control FSM with valid/ready memory handshake, wait-state
// timeout, full branch set and JALR/LUI/AUIPC. Outputs are forced low in reset.
module mc_controller_hs
   import mc_pkg::*;
#(
   parameter int ALUCTRL_W = 4,
   parameter int WAIT_MAX  = 255
)(
   input  logic                 clk,
   input  logic                 reset,
   input  logic [6:0]           op,
   input  logic [2:0]           funct3,
   input  logic                 funct7b5,
   input  logic                 zero,
   input  logic                 mem_ready,
   output logic                 mem_req,
   output logic                 WriteEnable,
   output logic [2:0]           immsrc,
   output logic [1:0]           alusrcA,
   output logic [1:0]           alusrcB,
   output logic [1:0]           resultsrc,
   output logic                 adrsrc,
   output logic [ALUCTRL_W-1:0] alucontrol,
   output logic                 irwrite,
   output logic                 pcwrite,
   output logic                 regwrite,
   output logic                 retire,
   output logic                 fault
);

   localparam int CNT_W = (WAIT_MAX > 0) ? $clog2(WAIT_MAX + 1) : 1;
   localparam logic [CNT_W-1:0] WAIT_LIMIT = CNT_W'(WAIT_MAX);

   mc_state_t        state_reg, state_next;
   logic [CNT_W-1:0] wait_cnt_reg, wait_cnt_next;
   logic             mem_state;
   logic             timeout;
   logic             branch_legal;
   logic             branch_taken;
   logic [1:0]       alu_class;
   logic [ALUCTRL_W-1:0] alu_code;

   assign branch_legal = (funct3[2:1] != 2'b01);
   // beq/bge/bgeu take the branch on zero; bne/blt/bltu on not-zero
   assign branch_taken = (funct3[2] ^ funct3[0]) ? !zero : zero;

   mc_aludec #(.ALUCTRL_W(ALUCTRL_W)) u_aludec (
      .alu_class  (alu_class),
      .funct3     (funct3),
      .funct7b5   (funct7b5),
      .rtype      (state_reg == S_EXECR),
      .alucontrol (alu_code)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_reg    <= S_FETCH;
         wait_cnt_reg <= '0;
      end else begin
         state_reg    <= state_next;
         wait_cnt_reg <= wait_cnt_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      mem_state  = (state_reg == S_FETCH) || (state_reg == S_MEMREAD) ||
                   (state_reg == S_MEMWRITE);
      timeout    = (WAIT_MAX != 0) && (wait_cnt_reg == WAIT_LIMIT);
      case (state_reg)
         S_FETCH: begin
            if (mem_ready)    state_next = S_DECODE;
            else if (timeout) state_next = S_FAULT;
         end
         S_DECODE: begin
            case (op)
               OP_LOAD, OP_STORE: state_next = S_MEMADR;
               OP_RTYPE:          state_next = S_EXECR;
               OP_ITYPE:          state_next = S_EXECI;
               OP_BRANCH:         state_next = S_BRANCH;
               OP_JAL:            state_next = S_JAL;
               OP_JALR:           state_next = S_JALR;
               OP_LUI:            state_next = S_LUI;
               OP_AUIPC:          state_next = S_AUIPC;
               default:           state_next = S_FAULT;
            endcase
         end
         S_MEMADR:   state_next = (op == OP_STORE) ? S_MEMWRITE : S_MEMREAD;
         S_MEMREAD: begin
            if (mem_ready)    state_next = S_MEMWB;
            else if (timeout) state_next = S_FAULT;
         end
         S_MEMWB:    state_next = S_FETCH;
         S_MEMWRITE: begin
            if (mem_ready)    state_next = S_FETCH;
            else if (timeout) state_next = S_FAULT;
         end
         S_EXECR, S_EXECI, S_JAL, S_JALR_LINK, S_LUI, S_AUIPC:
                     state_next = S_ALUWB;
         S_ALUWB:    state_next = S_FETCH;
         S_BRANCH:   state_next = branch_legal ? S_FETCH : S_FAULT;
         S_JALR:     state_next = S_JALR_LINK;
         S_FAULT:    state_next = S_FAULT;
         default:    state_next = S_FAULT;
      endcase

      // counter restarts on every state change, so each memory state starts at 0
      wait_cnt_next = wait_cnt_reg;
      if (state_next != state_reg)
         wait_cnt_next = '0;
      else if (mem_state && !mem_ready)
         wait_cnt_next = wait_cnt_reg + 1'b1;
   end

   always_comb begin
      mem_req     = 1'b0;
      WriteEnable = 1'b0;
      immsrc      = IMM_I;
      alusrcA     = SRCA_PC;
      alusrcB     = SRCB_RS2;
      resultsrc   = RES_ALUOUT;
      adrsrc      = 1'b0;
      alu_class   = ALU_CLS_ADD;
      irwrite     = 1'b0;
      pcwrite     = 1'b0;
      regwrite    = 1'b0;
      retire      = 1'b0;
      fault       = 1'b0;
      if (reset) begin
         if (state_reg != S_FAULT)
            immsrc = imm_type(op);
         case (state_reg)
            S_FETCH: begin
               mem_req   = 1'b1;
               alusrcA   = SRCA_PC;
               alusrcB   = SRCB_FOUR;
               resultsrc = RES_ALURESULT;
               irwrite   = mem_ready;
               pcwrite   = mem_ready;
            end
            S_DECODE: begin
               alusrcA = SRCA_OLDPC;
               alusrcB = SRCB_IMM;
            end
            S_MEMADR: begin
               alusrcA = SRCA_RS1;
               alusrcB = SRCB_IMM;
            end
            S_MEMREAD: begin
               mem_req   = 1'b1;
               adrsrc    = 1'b1;
               resultsrc = RES_ALUOUT;
            end
            S_MEMWB: begin
               resultsrc = RES_DATA;
               regwrite  = 1'b1;
               retire    = 1'b1;
            end
            S_MEMWRITE: begin
               mem_req     = 1'b1;
               WriteEnable = 1'b1;
               adrsrc      = 1'b1;
               retire      = mem_ready;
            end
            S_EXECR: begin
               alusrcA   = SRCA_RS1;
               alusrcB   = SRCB_RS2;
               alu_class = ALU_CLS_FUNCT;
            end
            S_EXECI: begin
               alusrcA   = SRCA_RS1;
               alusrcB   = SRCB_IMM;
               alu_class = ALU_CLS_FUNCT;
            end
            S_ALUWB: begin
               resultsrc = RES_ALUOUT;
               regwrite  = 1'b1;
               retire    = 1'b1;
            end
            S_BRANCH: begin
               alusrcA   = SRCA_RS1;
               alusrcB   = SRCB_RS2;
               resultsrc = RES_ALUOUT;
               alu_class = ALU_CLS_BRANCH;
               retire    = 1'b1;
               pcwrite   = branch_legal && branch_taken;
            end
            S_JAL: begin
               alusrcA   = SRCA_OLDPC;
               alusrcB   = SRCB_FOUR;
               resultsrc = RES_ALUOUT;
               pcwrite   = 1'b1;
            end
            S_JALR: begin
               alusrcA   = SRCA_RS1;
               alusrcB   = SRCB_IMM;
               resultsrc = RES_ALURESULT;
               pcwrite   = 1'b1;
            end
            S_JALR_LINK: begin
               alusrcA = SRCA_OLDPC;
               alusrcB = SRCB_FOUR;
            end
            S_LUI: begin
               alusrcA = SRCA_ZERO;
               alusrcB = SRCB_IMM;
            end
            S_AUIPC: begin
               alusrcA = SRCA_OLDPC;
               alusrcB = SRCB_IMM;
            end
            S_FAULT:  fault = 1'b1;
            default:  fault = 1'b1;
         endcase
      end
   end

   assign alucontrol = alu_code;

endmodule

// File: tb/tb_mc_controller_hs.sv
// Self-checking bench for mc_controller_hs: per-instruction step-list model
// checked every cycle, plus hand-computed latency/branch/fault expectations.
`timescale 1ns/1ps
module tb_mc_controller_hs;

   localparam int WMAX = 4;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic [6:0] op = 7'd0;
   logic [2:0] funct3 = 3'd0;
   logic       funct7b5 = 1'b0;
   logic       zero = 1'b0;
   logic       mem_ready = 1'b0;
   logic       mem_req, WriteEnable, adrsrc, irwrite, pcwrite, regwrite, retire, fault;
   logic [2:0] immsrc;
   logic [1:0] alusrcA, alusrcB, resultsrc;
   logic [3:0] alucontrol;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   mc_controller_hs #(.ALUCTRL_W(4), .WAIT_MAX(WMAX)) dut (
      .clk(clk), .reset(reset), .op(op), .funct3(funct3), .funct7b5(funct7b5),
      .zero(zero), .mem_ready(mem_ready), .mem_req(mem_req), .WriteEnable(WriteEnable),
      .immsrc(immsrc), .alusrcA(alusrcA), .alusrcB(alusrcB), .resultsrc(resultsrc),
      .adrsrc(adrsrc), .alucontrol(alucontrol), .irwrite(irwrite), .pcwrite(pcwrite),
      .regwrite(regwrite), .retire(retire), .fault(fault)
   );

   // One step of an instruction's life; memory steps repeat until mem_ready
   typedef struct packed {
      bit       mem;
      bit       fetch;
      bit       rdy_irpc;
      bit       rdy_ret;
      bit       to_fault;
      bit       mreq;
      bit       we;
      bit       adr;
      bit       pcw;
      bit       regw;
      bit       ret;
      bit [1:0] a;
      bit [1:0] b;
      bit [1:0] res;
      bit [3:0] alu;
   } step_t;

   step_t q[$];
   step_t m_cur;
   bit    m_fault = 1'b0;
   int    wcnt = 0;

   function automatic step_t st(input bit [1:0] a, input bit [1:0] b,
                                input bit [1:0] res, input bit [3:0] alu);
      step_t s;
      s = '0; s.a = a; s.b = b; s.res = res; s.alu = alu;
      return s;
   endfunction

   function automatic step_t fetch_step();
      step_t s;
      s = st(2'd0, 2'd2, 2'd2, 4'd0);
      s.mem = 1; s.fetch = 1; s.mreq = 1; s.rdy_irpc = 1;
      return s;
   endfunction

   function automatic step_t wb_step(input bit [1:0] res);
      step_t s;
      s = st(2'd0, 2'd0, res, 4'd0);
      s.regw = 1; s.ret = 1;
      return s;
   endfunction

   function automatic bit [3:0] alu_func(input bit [2:0] f3, input bit f7, input bit rtype);
      case (f3)
         3'b000:  return (rtype && f7) ? 4'd1 : 4'd0;
         3'b001:  return 4'd7;
         3'b010:  return 4'd5;
         3'b011:  return 4'd6;
         3'b100:  return 4'd4;
         3'b101:  return f7 ? 4'd9 : 4'd8;
         3'b110:  return 4'd3;
         default: return 4'd2;
      endcase
   endfunction

   function automatic bit [2:0] imm_of(input bit [6:0] o);
      case (o)
         7'b0100011:             return 3'd1;
         7'b1100011:             return 3'd2;
         7'b1101111:             return 3'd3;
         7'b0110111, 7'b0010111: return 3'd4;
         default:                return 3'd0;
      endcase
   endfunction

   // Append the post-fetch steps of an instruction to the model queue
   function automatic void build(input bit [6:0] o, input bit [2:0] f3,
                                 input bit f7, input bit z);
      step_t s;
      s = st(2'd1, 2'd1, 2'd0, 4'd0);
      case (o)
         7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011, 7'b1100011,
         7'b1101111, 7'b1100111, 7'b0110111, 7'b0010111: ;
         default: s.to_fault = 1;
      endcase
      q.push_back(s);
      case (o)
         7'b0000011: begin
            q.push_back(st(2'd2, 2'd1, 2'd0, 4'd0));
            s = st(2'd0, 2'd0, 2'd0, 4'd0); s.mem = 1; s.mreq = 1; s.adr = 1;
            q.push_back(s);
            q.push_back(wb_step(2'd1));
         end
         7'b0100011: begin
            q.push_back(st(2'd2, 2'd1, 2'd0, 4'd0));
            s = st(2'd0, 2'd0, 2'd0, 4'd0);
            s.mem = 1; s.mreq = 1; s.we = 1; s.adr = 1; s.rdy_ret = 1;
            q.push_back(s);
         end
         7'b0110011: begin
            q.push_back(st(2'd2, 2'd0, 2'd0, alu_func(f3, f7, 1'b1)));
            q.push_back(wb_step(2'd0));
         end
         7'b0010011: begin
            q.push_back(st(2'd2, 2'd1, 2'd0, alu_func(f3, f7, 1'b0)));
            q.push_back(wb_step(2'd0));
         end
         7'b1100011: begin
            s = st(2'd2, 2'd0, 2'd0, 4'd0);
            s.ret = 1;
            case (f3)
               3'b000: begin s.alu = 4'd1; s.pcw = z;  end
               3'b001: begin s.alu = 4'd1; s.pcw = !z; end
               3'b100: begin s.alu = 4'd5; s.pcw = !z; end
               3'b101: begin s.alu = 4'd5; s.pcw = z;  end
               3'b110: begin s.alu = 4'd6; s.pcw = !z; end
               3'b111: begin s.alu = 4'd6; s.pcw = z;  end
               default: s.to_fault = 1;
            endcase
            q.push_back(s);
         end
         7'b1101111: begin
            s = st(2'd1, 2'd2, 2'd0, 4'd0); s.pcw = 1;
            q.push_back(s);
            q.push_back(wb_step(2'd0));
         end
         7'b1100111: begin
            s = st(2'd2, 2'd1, 2'd2, 4'd0); s.pcw = 1;
            q.push_back(s);
            q.push_back(st(2'd1, 2'd2, 2'd0, 4'd0));
            q.push_back(wb_step(2'd0));
         end
         7'b0110111: begin
            q.push_back(st(2'd3, 2'd1, 2'd0, 4'd0));
            q.push_back(wb_step(2'd0));
         end
         7'b0010111: begin
            q.push_back(st(2'd1, 2'd1, 2'd0, 4'd0));
            q.push_back(wb_step(2'd0));
         end
         default: ;
      endcase
   endfunction

   always @(posedge clk or negedge reset) begin
      if (!reset) begin
         m_fault = 1'b0;
         wcnt = 0;
         q.delete();
         q.push_back(fetch_step());
      end else if (!m_fault && q.size() > 0) begin
         m_cur = q[0];
         if (m_cur.mem && !mem_ready) begin
            if (wcnt == WMAX) m_fault = 1'b1;
            else wcnt++;
         end else begin
            wcnt = 0;
            if (m_cur.to_fault) begin
               m_fault = 1'b1;
            end else begin
               void'(q.pop_front());
               if (m_cur.fetch) build(op, funct3, funct7b5, zero);
               if (q.size() == 0) q.push_back(fetch_step());
            end
         end
      end
   end

   function automatic logic [20:0] exp_vec();
      step_t s;
      bit    irpc, pcw, ret;
      if (!reset) return '0;
      if (m_fault) return {7'b0000001, 14'd0};
      if (q.size() == 0) return '1;
      s    = q[0];
      irpc = s.rdy_irpc && mem_ready;
      pcw  = s.pcw || irpc;
      ret  = s.ret || (s.rdy_ret && mem_ready);
      return {s.mreq, s.we, irpc, pcw, s.regw, ret, 1'b0, imm_of(op),
              s.a, s.b, s.res, s.adr, s.alu};
   endfunction

   logic [20:0] cmp_exp, cmp_act;

   always @(negedge clk) begin
      cmp_exp = exp_vec();
      cmp_act = {mem_req, WriteEnable, irwrite, pcwrite, regwrite, retire, fault,
                 immsrc, alusrcA, alusrcB, resultsrc, adrsrc, alucontrol};
      n_tests++;
      if (cmp_act !== cmp_exp) begin
         n_fail++;
         $display("FAIL cycle_outputs t=%0t got=%h want=%h", $time, cmp_act, cmp_exp);
      end
   end

   task automatic check(input string name, input int got, input int want);
      n_tests++;
      if (got != want) begin
         n_fail++;
         $display("FAIL %s got=%0d want=%0d", name, got, want);
      end
   endtask

   task automatic do_reset();
      reset = 1'b0;
      mem_ready = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("rst_mem_req", int'(mem_req), 0);
      check("rst_fault", int'(fault), 0);
      check("rst_alusrcB", int'(alusrcB), 0);
      @(posedge clk); #1;
      reset = 1'b1;
   endtask

   int ir_c, ret_c, flt_c, mreq_c;
   logic [3:0] p_alu;
   logic       p_pcw;

   // Runs ncyc cycles from the current FETCH; rdy_n bit c-1 = mem_ready low in cycle c
   task automatic run_instr(input logic [6:0] o, input logic [2:0] f3, input logic f7,
                            input logic z, input logic [31:0] rdy_n, input int ncyc,
                            input int probe);
      op = o; funct3 = f3; funct7b5 = f7; zero = z;
      ir_c = -1; ret_c = -1; flt_c = -1; mreq_c = -1;
      p_alu = 4'hF; p_pcw = 1'b0;
      for (int c = 1; c <= ncyc; c++) begin
         mem_ready = ~rdy_n[c-1];
         @(negedge clk);
         if (irwrite && ir_c < 0) ir_c = c;
         if (retire && ret_c < 0) ret_c = c;
         if (fault && flt_c < 0) flt_c = c;
         if (mem_req && mreq_c < 0) mreq_c = c;
         if (c == probe) begin p_alu = alucontrol; p_pcw = pcwrite; end
         @(posedge clk); #1;
      end
      $display("[TB] op=%b f3=%b f7b5=%0d zero=%0d: irwrite@%0d retire@%0d fault@%0d alu@%0d=%0d pcwrite=%0d",
               o, f3, f7, z, ir_c, ret_c, flt_c, probe, p_alu, p_pcw);
   endtask

   initial begin
      do_reset();

      run_instr(7'b0110011, 3'b000, 1'b0, 1'b0, 32'h0, 4, 3);
      check("add_irwrite", ir_c, 1);
      check("add_retire", ret_c, 4);
      check("add_alu", int'(p_alu), 0);

      run_instr(7'b0110011, 3'b000, 1'b1, 1'b0, 32'h0, 4, 3);
      check("sub_alu", int'(p_alu), 1);

      run_instr(7'b0000011, 3'b010, 1'b0, 1'b0, 32'h0F7, 10, 0);
      check("load_irwrite", ir_c, 4);
      check("load_retire", ret_c, 10);

      run_instr(7'b0100011, 3'b010, 1'b0, 1'b0, 32'h0, 4, 0);
      check("store_retire", ret_c, 4);

      run_instr(7'b1100011, 3'b001, 1'b0, 1'b0, 32'h0, 3, 3);
      check("bne_retire", ret_c, 3);
      check("bne_alu", int'(p_alu), 1);
      check("bne_pcwrite", int'(p_pcw), 1);

      run_instr(7'b1100011, 3'b101, 1'b0, 1'b1, 32'h0, 3, 3);
      check("bge_alu", int'(p_alu), 5);
      check("bge_pcwrite", int'(p_pcw), 1);

      run_instr(7'b1100011, 3'b110, 1'b0, 1'b1, 32'h0, 3, 3);
      check("bltu_alu", int'(p_alu), 6);
      check("bltu_pcwrite", int'(p_pcw), 0);

      run_instr(7'b1100011, 3'b000, 1'b0, 1'b0, 32'h0, 3, 3);
      check("beq_pcwrite", int'(p_pcw), 0);

      run_instr(7'b1101111, 3'b000, 1'b0, 1'b0, 32'h0, 4, 0);
      check("jal_retire", ret_c, 4);
      run_instr(7'b1100111, 3'b000, 1'b0, 1'b0, 32'h0, 5, 0);
      check("jalr_retire", ret_c, 5);
      run_instr(7'b0110111, 3'b000, 1'b0, 1'b0, 32'h0, 4, 0);
      check("lui_retire", ret_c, 4);
      run_instr(7'b0010111, 3'b000, 1'b0, 1'b0, 32'h0, 4, 0);
      check("auipc_retire", ret_c, 4);
      run_instr(7'b0010011, 3'b101, 1'b1, 1'b0, 32'h0, 4, 3);
      check("srai_alu", int'(p_alu), 9);
      run_instr(7'b0010011, 3'b000, 1'b1, 1'b0, 32'h0, 4, 3);
      check("addi_f7_alu", int'(p_alu), 0);

      run_instr(7'b0110011, 3'b000, 1'b0, 1'b0, 32'h0000000F, 8, 0);
      check("lastwait_irwrite", ir_c, 5);
      check("lastwait_retire", ret_c, 8);
      check("lastwait_nofault", flt_c, -1);

      run_instr(7'b0110011, 3'b000, 1'b0, 1'b0, 32'hFFFFFFFF, 9, 0);
      check("timeout_fault_cycle", flt_c, 6);
      check("timeout_fault_sticky", int'(fault), 1);
      do_reset();

      run_instr(7'b0000000, 3'b000, 1'b0, 1'b0, 32'h0, 4, 0);
      check("illegal_fault_cycle", flt_c, 3);
      do_reset();
      run_instr(7'b0110011, 3'b000, 1'b0, 1'b0, 32'h0, 4, 0);
      check("post_reset_mem_req", mreq_c, 1);
      check("post_reset_retire", ret_c, 4);

      run_instr(7'b0100011, 3'b010, 1'b0, 1'b0, 32'h0, 3, 0);
      mem_ready = 1'b0;
      @(negedge clk);
      check("memwrite_we_before", int'(WriteEnable), 1);
      #2 reset = 1'b0;
      #1;
      check("memwrite_we_async", int'(WriteEnable), 0);
      check("memwrite_req_async", int'(mem_req), 0);
      do_reset();
      run_instr(7'b0110011, 3'b000, 1'b0, 1'b0, 32'h0, 4, 0);
      check("after_abort_retire", ret_c, 4);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog t=%0t", $time);
      $fatal(1, "watchdog");
   end

endmodule
